// File: rtl/div_unit_if.sv
// div_unit_if: operand/result handshake bundle between the execute stage and div_unit.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               annul;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU, returns {HI=rem, LO=quo}.
// Optional DIV_ZERO_FAST_EN: a zero divisor completes one cycle after acceptance.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   div_if
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
`ifdef DIV_ZERO_FAST_EN
    S_ZERO = 2'd3,
`endif
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   absb_q, absb_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               bz_q, bz_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               sgn_a;
  logic               sgn_b;

  // One restoring step: shift {rem, quo}, subtract |b| when it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, absb_q});
    diff   = rem_sh[WIDTH-1:0] - absb_q;
    rem_n  = ge ? diff : rem_sh[WIDTH-1:0];
    quo_n  = {quo_q[WIDTH-2:0], ge};
    q_fix  = negq_q ? -quo_n : quo_n;
    r_fix  = negr_q ? -rem_n : rem_n;
    sgn_a  = div_if.signed_div & div_if.a[WIDTH-1];
    sgn_b  = div_if.signed_div & div_if.b[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    absb_d   = absb_q;
    a_d      = a_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    bz_d     = bz_q;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (div_if.start && !div_if.annul) begin
          a_d     = div_if.a;
          negq_d  = sgn_a ^ sgn_b;
          negr_d  = sgn_a;
          bz_d    = (div_if.b == '0);
          quo_d   = sgn_a ? -div_if.a : div_if.a;
          absb_d  = sgn_b ? -div_if.b : div_if.b;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (div_if.b == '0) begin
            state_d  = S_ZERO;
            ready_d  = 1'b1;
            result_d = {div_if.a, {WIDTH{1'b1}}};
          end
`endif
        end
      end

      S_BUSY: begin
        if (div_if.annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = rem_n;
          quo_d  = quo_n;
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          // Final step: load the corrected result so ready and result land together in DONE.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = S_DONE;
            ready_d  = 1'b1;
            result_d = bz_q ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
`ifdef DIV_ZERO_FAST_EN
      S_ZERO:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      absb_q   <= '0;
      a_q      <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      absb_q   <= absb_d;
      a_q      <= a_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      bz_q     <= bz_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign div_if.busy   = busy_q;
  assign div_if.ready  = ready_q;
  assign div_if.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit with hand-computed results.
// Zero-divisor latency expectation follows DIV_ZERO_FAST_EN.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive start for one cycle; returns at the mid-point of cycle T+1.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.a          = a;
    bus.b          = b;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Counts cycles (from lat0) and busy cycles until ready, bounded.
  task automatic wait_ready(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (1'b1) begin
      if (bus.busy) bcnt++;
      if (bus.ready || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat, bcnt;
    launch(sgn, a, b);
    wait_ready(1, lat, bcnt);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
    @(negedge clk);
    check({tag, " busy after"}, 64'(bus.busy), 64'd0);
    check({tag, " ready after"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, saw;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.annul = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset ready", 64'(bus.ready), 64'd0);
    check("reset result", bus.result, 64'd0);

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    run_div("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);
    run_div("divu by zero", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, ZLAT);
    run_div("div by zero", 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, ZLAT);

    // Second start mid-flight with new operands must not disturb the first divide.
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.signed_div = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h1;
    wait_ready(6, lat, bcnt);
    check("restart latency", 64'(lat), 64'd33);
    check("restart result", bus.result, {32'd2, 32'd14});

    // Annul in BUSY: back to idle, no ready, result held.
    @(negedge clk);
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul busy", 64'(bus.busy), 64'd0);
    check("annul ready", 64'(bus.ready), 64'd0);
    check("annul result", bus.result, {32'd2, 32'd14});
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready) saw = 1;
    end
    check("annul no ready", 64'(saw), 64'd0);

    // Annul in IDLE blocks a same-cycle start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    check("idle annul busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("idle annul busy2", 64'(bus.busy), 64'd0);

    // Reset mid-operation, then a fresh divide completes normally.
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst ready", 64'(bus.ready), 64'd0);
    check("midrst result", bus.result, 64'd0);
    run_div("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);

    // Start held across the ready cycle is taken one cycle later.
    launch(1'b0, 32'd50, 32'd5);
    wait_ready(1, lat, bcnt);
    check("pre-collide result", bus.result, {32'd0, 32'd10});
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.a = 32'd9;
    bus.b = 32'd2;
    @(negedge clk);
    check("start on ready ignored", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("start accepted in idle", 64'(bus.busy), 64'd1);
    wait_ready(1, lat, bcnt);
    check("collide latency", 64'(lat), 64'd33);
    check("collide result", bus.result, {32'd1, 32'd4});
    @(negedge clk);
    check("collide done busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
